// File: rtl/systolic_col_feeder.sv
// Column feeder for a systolic array: loads LENGTH words into an external RAM, then streams them to a PE.
// Optional macro FEED_REPEAT_EN lets the repeat_i input keep the stream running pass after pass.
module systolic_col_feeder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int LENGTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              repeat_i,
  input  logic              ready_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_di_o,
  input  logic [DATA_W-1:0] ram_do_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              load_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] LEN_C  = (ADDR_W+1)'(LENGTH);
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(LENGTH - 1);
  localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_C = (ADDR_W+1)'(0);

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0] rd_cnt_q, rd_cnt_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            load_done_q, load_done_d;

  logic            wr_s;
  logic            rd_s;
  logic            hs_s;
  logic            wrap_s;

`ifdef FEED_REPEAT_EN
  assign wrap_s = repeat_i;
`else
  // repeat_i stays on the port list for pin compatibility but never influences the stream
  assign wrap_s = repeat_i & 1'b0;
`endif

  assign wr_s = (state_q == ST_LOAD) && load_valid_i;
  assign rd_s = (state_q == ST_STREAM) && (rd_cnt_q < LEN_C) && (!valid_q || ready_i);
  assign hs_s = valid_q && ready_i;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    load_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          state_d  = ST_LOAD;
          wr_cnt_d = ZERO_C;
        end else if (start_i) begin
          state_d  = ST_STREAM;
          rd_cnt_d = ZERO_C;
          valid_d  = 1'b0;
          last_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (wr_s && (wr_cnt_q == LAST_C)) begin
          state_d     = ST_IDLE;
          wr_cnt_d    = ZERO_C;
          load_done_d = 1'b1;
        end else if (wr_s) begin
          wr_cnt_d = wr_cnt_q + ONE_C;
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      ST_STREAM: begin
        // last_q marks that the word on data_out is the final address of a pass
        if (rd_s) begin
          valid_d  = 1'b1;
          last_d   = (rd_cnt_q == LAST_C);
          rd_cnt_d = ((rd_cnt_q == LAST_C) && wrap_s) ? ZERO_C : rd_cnt_q + ONE_C;
        end else if (hs_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
        if (hs_s && last_q) begin
          done_d = 1'b1;
          if (!rd_s && (rd_cnt_q == LEN_C)) begin
            state_d  = ST_IDLE;
            rd_cnt_d = ZERO_C;
            valid_d  = 1'b0;
            last_d   = 1'b0;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_cnt_d = ZERO_C;
        rd_cnt_d = ZERO_C;
        valid_d  = 1'b0;
        last_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= ZERO_C;
      rd_cnt_q    <= ZERO_C;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      load_done_q <= load_done_d;
    end
  end

  // RAM port is combinational so a read can react to ready_i in the same cycle
  assign ram_en_o   = wr_s | rd_s;
  assign ram_we_o   = wr_s;
  assign ram_addr_o = wr_s ? wr_cnt_q[ADDR_W-1:0] : (rd_s ? rd_cnt_q[ADDR_W-1:0] : '0);
  assign ram_di_o   = wr_s ? load_data_i : '0;

  assign data_out_o   = ram_do_i;
  assign data_valid_o = valid_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign load_done_o  = load_done_q;

endmodule

// File: tb/tb_systolic_col_feeder.sv
// Self-checking bench for systolic_col_feeder: behavioural RAM, monitor queues and a queue-based reference.
module tb_systolic_col_feeder;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int LEN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          rpt = 1'b0;
  logic          ready = 1'b0;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;
  logic [DW-1:0] data_out;
  logic          data_valid, busy, done, load_done;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] mem [LEN];
  logic [DW-1:0] ref_mem [LEN];
  logic [DW-1:0] seq [LEN] = '{16'd0, 16'd0, 16'd5, 16'd9, 16'd13, 16'd6, 16'd10, 16'd14,
                               16'd7, 16'd11, 16'd15, 16'd8, 16'd12, 16'd16, 16'd0, 16'd0};

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  logic [DW-1:0] got_q [$];
  int hs_cyc_q [$];
  int rise_q [$];
  int wr_addr_q [$];
  int done_cnt = 0, done_cyc = 0, ld_cnt = 0, ld_cyc = 0, last_wr_cyc = 0, viol = 0;
  logic prev_valid = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  systolic_col_feeder #(.DATA_W(DW), .ADDR_W(AW), .LENGTH(LEN)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .load_start_i(load_start),
    .load_valid_i(load_valid), .load_data_i(load_data), .repeat_i(rpt), .ready_i(ready),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_di_o(ram_di),
    .ram_do_i(ram_do), .data_out_o(data_out), .data_valid_o(data_valid), .busy_o(busy),
    .done_o(done), .load_done_o(load_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read, read data held while disabled; bd_* is a preload backdoor
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else ram_do <= mem[ram_addr];
    end
  end

  // Observe outputs mid-cycle and record handshakes, pulses, writes and protocol breaches
  always @(negedge clk) begin
    if (data_valid && ready) begin
      got_q.push_back(data_out);
      hs_cyc_q.push_back(cyc);
    end
    if (data_valid && !prev_valid) rise_q.push_back(cyc);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (load_done) begin
      ld_cnt <= ld_cnt + 1;
      ld_cyc <= cyc;
    end
    if (ram_we) begin
      wr_addr_q.push_back(int'(ram_addr));
      last_wr_cyc <= cyc;
    end
    if ((data_valid && !ready && ram_en) || (ram_we && !ram_en) ||
        (!busy && (ram_en || ram_we || data_valid)) ||
        (prev_stall && (!data_valid || data_out !== prev_data)))
      viol <= viol + 1;
    prev_valid <= data_valid;
    prev_stall <= data_valid && !ready && !rst;
    prev_data  <= data_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 3 cycles while word 5 is shown
  task automatic run_stream(input int mode, input int inject, input bit rpt_en,
                            input int exp_words, input int exp_done);
    int t0, k, g0, r0, d0, w0, n;
    g0 = got_q.size(); r0 = rise_q.size(); d0 = done_cnt; w0 = wr_addr_q.size();
    t0 = cyc; k = 0;
    start = 1'b1; rpt = rpt_en; ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    do begin
      tick(); k++;
      start = 1'b0; load_start = 1'b0;
      if (k == inject) begin
        start = 1'b1;
        load_start = 1'b1;
      end
      if (rpt_en && (got_q.size() - g0 >= 20)) rpt = 1'b0;
      case (mode)
        0: ready = 1'b1;
        2: ready = !(k >= 7 && k <= 9);
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
    end while (!((done_cnt - d0 >= exp_done) && !busy) && k < 400);
    ready = 1'b0; rpt = 1'b0; start = 1'b0; load_start = 1'b0;
    check("stream_timeout", k < 400, 1);
    n = got_q.size() - g0;
    check("word_count", n, exp_words);
    for (int i = 0; i < n && i < exp_words; i++) begin
      check("word", got_q[g0 + i], ref_mem[i % LEN]);
      if (mode != 1)
        check("word_cycle", hs_cyc_q[g0 + i] - t0, 2 + i + ((mode == 2 && i >= 5) ? 3 : 0));
    end
    check("done_count", done_cnt - d0, exp_done);
    if (n > 0) check("done_after_last", done_cyc, hs_cyc_q[hs_cyc_q.size() - 1] + 1);
    if (mode != 1) check("done_cycle", done_cyc - t0, 2 + exp_words + ((mode == 2) ? 3 : 0));
    check("first_valid", (rise_q.size() > r0) ? rise_q[r0] - t0 : -1, 2);
    check("stream_no_writes", wr_addr_q.size() - w0, 0);
    check("protocol", viol, 0);
    check("idle_after_stream", {busy, data_valid}, 0);
  endtask

  task automatic do_load(input bit with_start, input bit rnd);
    int n, k, l0, w0;
    logic [DW-1:0] v;
    l0 = ld_cnt; w0 = wr_addr_q.size();
    load_start = 1'b1; start = with_start;
    tick();
    load_start = 1'b0; start = 1'b0;
    check("load_busy", busy, 1);
    n = 0; k = 0;
    while (ld_cnt == l0 && k < 300) begin
      if (n < LEN && $urandom_range(0, 2) != 0) begin
        v = rnd ? DW'($urandom) : DW'(100 + n);
        load_valid = 1'b1; load_data = v; ref_mem[n] = v;
        n++;
      end else begin
        load_valid = 1'b0; load_data = DW'($urandom);
      end
      tick(); k++;
    end
    load_valid = 1'b0;
    check("load_timeout", k < 300, 1);
    check("load_done_count", ld_cnt - l0, 1);
    check("load_done_timing", ld_cyc, last_wr_cyc + 1);
    check("write_count", wr_addr_q.size() - w0, LEN);
    for (int i = 0; i < LEN && (w0 + i) < wr_addr_q.size(); i++)
      check("write_addr", wr_addr_q[w0 + i], i);
    check("idle_after_load", busy, 0);
  endtask

  initial begin
    int t0, d0;
    tick(); tick();
    for (int i = 0; i < LEN; i++) begin
      bd_we = 1'b1; bd_addr = AW'(i); bd_data = seq[i]; ref_mem[i] = seq[i];
      tick();
    end
    bd_we = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_done", done, 0);
    check("rst_load_done", load_done, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_di", ram_di, 0);
    rst = 1'b0;
    tick();

    run_stream(0, -1, 1'b0, LEN, 1);
    run_stream(2, -1, 1'b0, LEN, 1);
    do_load(1'b0, 1'b0);
    run_stream(1, -1, 1'b0, LEN, 1);
    do_load(1'b1, 1'b1);
    run_stream(1, 5, 1'b0, LEN, 1);
    run_stream(1, -1, 1'b0, LEN, 1);

    // reset while word 7 is on data_out
    d0 = done_cnt; t0 = cyc;
    start = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      start = 1'b0;
    end
    check("pre_rst_word7", data_out, ref_mem[7]);
    rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", data_valid, 0);
    check("post_rst_done", done, 0);
    tick(); tick();
    check("post_rst_no_done", done_cnt - d0, 0);
    run_stream(0, -1, 1'b0, LEN, 1);

`ifdef FEED_REPEAT_EN
    run_stream(0, -1, 1'b1, 2 * LEN, 2);
    run_stream(1, -1, 1'b1, 2 * LEN, 2);
`else
    run_stream(0, -1, 1'b1, LEN, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

endmodule
